memory_arbiter: RTL and testbench

Sequential arbiter that shares the single-port unified RAM between the instruction-fetch path and the data-memory path of the datapath. The control unit's decoded `dREN`/`dWEN` and the PC fetch request both compete for this RAM. The block serializes their requests through a grant state machine and holds each grant until the RAM reports completion. It also guarantees forward progress for instruction fetch under sustained load/store traffic.

---
 rtl/memory_arbiter_if.sv | 33 +++
 rtl/memory_arbiter.sv | 104 ++++++++++
 tb/tb_memory_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the unified RAM.
//   slave  : arbiter view (requests and RAM status in; waits, loads, RAM request out)
//   master : environment view (requesters + RAM drive the opposite directions)
// Signals keep their original names: iREN/iaddr/iwait/iload, dREN/dWEN/daddr/
// dstore/dwait/dload, ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates the single-port unified RAM between instruction fetch and data
// access. A grant is chosen when leaving IDLE and held until the RAM reports
// ACCESS (completion), ERROR (abort) or the requester withdraws. Data wins
// contention unless STARVE_LIMIT data grants have completed back-to-back while
// a fetch was waiting.
// Ports:
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset
//   mif  : memory_arbiter_if.slave (requester and RAM signals)
module memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic            CLK,
  input logic            nRST,
  memory_arbiter_if.slave mif
);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;
  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       d_req;
  logic       i_cplt;
  logic       d_cplt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mif.ramREN   = 1'b0;
    mif.ramWEN   = 1'b0;
    mif.ramaddr  = '0;
    mif.ramstore = '0;
    mif.iload    = '0;
    mif.dload    = '0;

    d_req  = mif.dREN | mif.dWEN;
    i_cplt = (state_q == IGNT) && (mif.ramstate == RAM_ACCESS);
    d_cplt = (state_q == DGNT) && (mif.ramstate == RAM_ACCESS);

    mif.iwait = mif.iREN & ~i_cplt;
    mif.dwait = d_req & ~d_cplt;

    unique case (state_q)
      IDLE: begin
        if (d_req && !(mif.iREN && (starve_cnt_q >= LIMIT))) begin
          state_d = DGNT;
        end else if (mif.iREN) begin
          state_d = IGNT;
        end
      end

      DGNT: begin
        mif.ramREN   = mif.dREN;
        mif.ramWEN   = mif.dWEN;
        mif.ramaddr  = mif.daddr;
        mif.ramstore = mif.dstore;
        // Withdrawal takes precedence so a dropped request never sees a load pulse.
        if (!d_req) begin
          state_d = IDLE;
        end else if (mif.ramstate == RAM_ACCESS) begin
          mif.dload = mif.ramload;
          state_d   = IDLE;
          if (mif.iREN) begin
            starve_cnt_d = (starve_cnt_q == 4'hF) ? starve_cnt_q : starve_cnt_q + 4'd1;
          end else begin
            starve_cnt_d = '0;
          end
        end else if (mif.ramstate == RAM_ERROR) begin
          state_d = IDLE;
        end
      end

      IGNT: begin
        mif.ramREN  = 1'b1;
        mif.ramaddr = mif.iaddr;
        if (!mif.iREN) begin
          state_d = IDLE;
        end else if (mif.ramstate == RAM_ACCESS) begin
          mif.iload    = mif.ramload;
          starve_cnt_d = '0;
          state_d      = IDLE;
        end else if (mif.ramstate == RAM_ERROR) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios followed by a randomized phase.
// In the random phase the bench plays both requesters and a RAM whose read
// data is a fixed function of the address; expected responses are queued at
// request time and popped by an independent monitor on completion.
module tb_memory_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_arbiter_if mif();

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK (clk),
    .nRST(rst_n),
    .mif (mif)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t iq[$];
  txn_t dq[$];
  bit   rnd_on = 1'b0;
  bit   i_done = 1'b0, d_done = 1'b0;
  int   consec = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap();
    mif.iREN = 1'b0; mif.dREN = 1'b0; mif.dWEN = 1'b0;
    mif.ramstate = FREE; mif.ramload = '0;
    nxt();
    nxt();
  endtask

  // Monitor: active in the random phase only.
  always @(negedge clk) begin
    if (rnd_on) begin
      txn_t t;
      if (mif.iREN && !mif.iwait) begin
        if (iq.size() == 0) begin
          chk("i_unexpected", 32'd1, 32'd0);
        end else begin
          t = iq.pop_front();
          chk("i_load", mif.iload, mem_val(t.addr));
          chk("i_addr", mif.ramaddr, t.addr);
          chk("i_ren", {31'd0, mif.ramREN}, 32'd1);
          chk("i_wen", {31'd0, mif.ramWEN}, 32'd0);
        end
        i_done = 1'b1;
        consec = 0;
      end else begin
        chk("i_load_quiet", mif.iload, 32'd0);
      end
      if ((mif.dREN || mif.dWEN) && !mif.dwait) begin
        if (dq.size() == 0) begin
          chk("d_unexpected", 32'd1, 32'd0);
        end else begin
          t = dq.pop_front();
          chk("d_addr", mif.ramaddr, t.addr);
          if (t.wr) begin
            chk("d_wen", {31'd0, mif.ramWEN}, 32'd1);
            chk("d_store", mif.ramstore, t.data);
          end else begin
            chk("d_ren", {31'd0, mif.ramREN}, 32'd1);
            chk("d_load", mif.dload, mem_val(t.addr));
          end
        end
        n_cmp++;
        if (consec >= int'(LIMIT)) begin
          n_err++;
          $display("FAIL starve: data completion with %0d prior while fetch waiting, limit %0d", consec, LIMIT);
        end
        consec = mif.iREN ? consec + 1 : 0;
        d_done = 1'b1;
      end else begin
        chk("d_load_quiet", mif.dload, 32'd0);
      end
    end
  end

  initial begin
    bit   i_pend, d_pend, wr;
    byte  seq[$];
    int   ihigh, r;

    mif.iREN = 1'b0; mif.iaddr = '0; mif.dREN = 1'b1; mif.dWEN = 1'b0;
    mif.daddr = 32'h10; mif.dstore = '0; mif.ramload = 32'h1111_2222; mif.ramstate = ACCESS;

    // Reset state
    #3;
    chk("rst_ramREN", {31'd0, mif.ramREN}, 32'd0);
    chk("rst_ramaddr", mif.ramaddr, 32'd0);
    chk("rst_dload", mif.dload, 32'd0);
    chk("rst_dwait", {31'd0, mif.dwait}, 32'd1);
    chk("rst_iwait", {31'd0, mif.iwait}, 32'd0);
    mif.dREN = 1'b0; mif.ramstate = FREE; mif.ramload = '0;
    @(posedge clk); #3 rst_n = 1'b1;
    nxt();

    // Single fetch
    mif.iREN = 1'b1; mif.iaddr = 32'h40; #1;
    chk("fetch_c0_iwait", {31'd0, mif.iwait}, 32'd1);
    chk("fetch_c0_ramREN", {31'd0, mif.ramREN}, 32'd0);
    nxt(); mif.ramstate = ACCESS; mif.ramload = 32'h2001_0005; #1;
    chk("fetch_c1_iwait", {31'd0, mif.iwait}, 32'd0);
    chk("fetch_c1_iload", mif.iload, 32'h2001_0005);
    chk("fetch_c1_ramaddr", mif.ramaddr, 32'h40);
    nxt(); mif.iREN = 1'b0; mif.ramstate = FREE; mif.ramload = '0; #1;
    chk("fetch_after_iload", mif.iload, 32'd0);
    idle_gap();

    // Contention: data first, fetch after one idle cycle
    mif.iREN = 1'b1; mif.iaddr = 32'h44; mif.dWEN = 1'b1;
    mif.daddr = 32'h80; mif.dstore = 32'hDEAD_BEEF; #1;
    chk("cont_c0_dwait", {31'd0, mif.dwait}, 32'd1);
    nxt(); mif.ramstate = ACCESS; #1;
    chk("cont_dgnt_wen", {31'd0, mif.ramWEN}, 32'd1);
    chk("cont_dgnt_ren", {31'd0, mif.ramREN}, 32'd0);
    chk("cont_dgnt_addr", mif.ramaddr, 32'h80);
    chk("cont_dgnt_store", mif.ramstore, 32'hDEAD_BEEF);
    chk("cont_dgnt_dwait", {31'd0, mif.dwait}, 32'd0);
    chk("cont_dgnt_iwait", {31'd0, mif.iwait}, 32'd1);
    nxt(); mif.dWEN = 1'b0; mif.ramstate = FREE; #1;
    chk("cont_idle_addr", mif.ramaddr, 32'd0);
    nxt(); mif.ramstate = ACCESS; mif.ramload = 32'h1234; #1;
    chk("cont_ignt_addr", mif.ramaddr, 32'h44);
    chk("cont_ignt_iload", mif.iload, 32'h1234);
    nxt(); idle_gap();

    // Starvation limit: both requests held, RAM always answers at once
    mif.iREN = 1'b1; mif.dREN = 1'b1; mif.iaddr = 32'h48; mif.daddr = 32'h90;
    mif.ramstate = ACCESS; mif.ramload = 32'h77;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (!mif.dwait) seq.push_back("D");
      if (!mif.iwait) seq.push_back("I");
      nxt();
    end
    chk("starve_count", seq.size(), 32'd15);
    for (int k = 0; k < seq.size(); k++) begin
      chk($sformatf("starve_seq%0d", k), {24'd0, seq[k]}, (k % 5 == 4) ? "I" : "D");
    end
    idle_gap();

    // BUSY stall in IGNT
    ihigh = 0;
    mif.iREN = 1'b1; mif.iaddr = 32'h4C; mif.ramstate = BUSY; #1;
    if (mif.iwait) ihigh++;
    for (int c = 1; c <= 4; c++) begin
      nxt(); mif.ramstate = (c == 4) ? ACCESS : BUSY; mif.ramload = 32'hCAFE; #1;
      chk($sformatf("busy_c%0d_ren", c), {31'd0, mif.ramREN}, 32'd1);
      chk($sformatf("busy_c%0d_addr", c), mif.ramaddr, 32'h4C);
      if (mif.iwait) ihigh++;
      if (c == 4) chk("busy_iload", mif.iload, 32'hCAFE);
    end
    chk("busy_iwait_cycles", ihigh, 32'd4);
    nxt(); idle_gap();

    // ERROR in DGNT keeps starve count: 3 data completions, error, retry, then fetch
    mif.iREN = 1'b1; mif.dREN = 1'b1; mif.iaddr = 32'h50; mif.daddr = 32'hA0;
    mif.ramstate = ACCESS; mif.ramload = 32'h99;
    for (int c = 1; c <= 11; c++) begin
      nxt(); mif.ramstate = (c == 7) ? ERROR : ACCESS; #1;
      case (c)
        1, 3, 5: chk($sformatf("err_d%0d_dwait", c), {31'd0, mif.dwait}, 32'd0);
        7: begin
          chk("err_dwait", {31'd0, mif.dwait}, 32'd1);
          chk("err_dload", mif.dload, 32'd0);
        end
        8: begin
          chk("err_idle_addr", mif.ramaddr, 32'd0);
          chk("err_idle_dwait", {31'd0, mif.dwait}, 32'd1);
        end
        9: begin
          chk("err_regrant_addr", mif.ramaddr, 32'hA0);
          chk("err_regrant_dwait", {31'd0, mif.dwait}, 32'd0);
        end
        11: begin
          chk("err_fetch_addr", mif.ramaddr, 32'h50);
          chk("err_fetch_iwait", {31'd0, mif.iwait}, 32'd0);
        end
        default: ;
      endcase
    end
    nxt(); idle_gap();

    // Withdrawal in DGNT
    mif.dREN = 1'b1; mif.daddr = 32'h100; mif.ramstate = FREE;
    nxt(); #1;
    chk("wd_dgnt_addr", mif.ramaddr, 32'h100);
    nxt(); mif.dREN = 1'b0; mif.ramstate = ACCESS; mif.ramload = 32'hBAD; #1;
    chk("wd_dload", mif.dload, 32'd0);
    nxt(); #1;
    chk("wd_idle_addr", mif.ramaddr, 32'd0);
    chk("wd_idle_dload", mif.dload, 32'd0);
    idle_gap();

    // Asynchronous reset in the middle of DGNT
    mif.dREN = 1'b1; mif.daddr = 32'h200; mif.ramstate = BUSY;
    nxt(); #1;
    chk("rstm_dgnt_ren", {31'd0, mif.ramREN}, 32'd1);
    #1 rst_n = 1'b0; #1;
    chk("rstm_ren", {31'd0, mif.ramREN}, 32'd0);
    chk("rstm_addr", mif.ramaddr, 32'd0);
    chk("rstm_dload", mif.dload, 32'd0);
    chk("rstm_dwait", {31'd0, mif.dwait}, 32'd1);
    nxt();
    #2 rst_n = 1'b1; #1;
    chk("rstm_idle_ren", {31'd0, mif.ramREN}, 32'd0);
    nxt(); mif.ramstate = ACCESS; mif.ramload = 32'h5; #1;
    chk("rstm_regrant_addr", mif.ramaddr, 32'h200);
    chk("rstm_regrant_dload", mif.dload, 32'h5);
    nxt(); idle_gap();

    // Randomized phase
    i_pend = 1'b0; d_pend = 1'b0; consec = 0;
    rnd_on = 1'b1;
    for (int c = 0; c < 3500; c++) begin
      @(posedge clk); #1;
      if (i_done) begin i_done = 1'b0; i_pend = 1'b0; mif.iREN = 1'b0; end
      if (d_done) begin d_done = 1'b0; d_pend = 1'b0; mif.dREN = 1'b0; mif.dWEN = 1'b0; end
      if (c < 3000) begin
        if (!i_pend && $urandom_range(0, 2) == 0) begin
          mif.iaddr = $urandom & 32'hFFFF_FFFC;
          mif.iREN = 1'b1; i_pend = 1'b1;
          iq.push_back('{wr: 1'b0, addr: mif.iaddr, data: 32'd0});
        end
        if (!d_pend && $urandom_range(0, 1) == 0) begin
          wr = 1'($urandom_range(0, 1));
          mif.daddr = $urandom & 32'hFFFF_FFFC;
          mif.dstore = $urandom;
          mif.dREN = !wr; mif.dWEN = wr; d_pend = 1'b1;
          dq.push_back('{wr: wr, addr: mif.daddr, data: mif.dstore});
        end
      end else if (!i_pend && !d_pend) begin
        break;
      end
      #1;
      r = $urandom_range(0, 9);
      mif.ramstate = (r < 4) ? ACCESS : (r < 6) ? FREE : (r < 9) ? BUSY : ERROR;
      mif.ramload = (mif.ramREN || mif.ramWEN) ? mem_val(mif.ramaddr) : $urandom;
    end
    @(posedge clk); #1;
    rnd_on = 1'b0;
    chk("drain_iq", iq.size(), 32'd0);
    chk("drain_dq", dq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
